// File: rtl/cmd_fetch.sv
// cmd_fetch: walks a word-aligned command stream in the command BRAM and decodes opcodes,
//   emitting one command handshake per command plus 128-bit operand beats.
// Latency: start -> cmd_valid 2 cycles; one operand beat per 2 cycles with data_ready held high.
// Backpressure: cmd_* and data hold stable while their valid is high and ready is low.
// Ports: start/base_addr/end_addr control; busy/done/err status;
//   addr1/read0 and addr2/read1..read4 to the command BRAM (combinational read data);
//   cmd_* and data* valid/ready streams to the transform pipeline.
module cmd_fetch #(
  parameter logic [7:0] OP_MATRIX_MODE = 8'h10,
  parameter logic [7:0] OP_VERTEX      = 8'h11,
  parameter logic [7:0] OP_LOAD_MATRIX = 8'h13
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [31:0]  base_addr,
  input  logic [31:0]  end_addr,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [31:0]  addr1,
  input  logic [31:0]  read0,
  output logic [31:0]  addr2,
  input  logic [31:0]  read1,
  input  logic [31:0]  read2,
  input  logic [31:0]  read3,
  input  logic [31:0]  read4,
  output logic         cmd_valid,
  input  logic         cmd_ready,
  output logic [7:0]   cmd_op,
  output logic [3:0]   cmd_mode,
  output logic [31:0]  cmd_word,
  output logic         data_valid,
  input  logic         data_ready,
  output logic [127:0] data,
  output logic         data_last
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    CMD   = 3'd2,
    LOAD  = 3'd3,
    DATA  = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc;
  logic [2:0]  beats_left;

  // Opcode decode of the word currently at pc.
  logic        op_known;
  logic [2:0]  op_beats;
  logic [31:0] op_end;
  logic        at_end;
  logic        truncated;

  always_comb begin
    op_known = 1'b1;
    op_beats = 3'd0;
    case (read0[7:0])
      OP_MATRIX_MODE: op_beats = 3'd0;
      OP_VERTEX:      op_beats = 3'd1;
      OP_LOAD_MATRIX: op_beats = 3'd4;
      default:        op_known = 1'b0;
    endcase
  end

  // End of this command's operands (exclusive); 32-bit wrap is intended.
  assign op_end    = pc + 32'd4 + {25'd0, op_beats, 4'd0};
  assign at_end    = (pc >= end_addr);
  assign truncated = (op_end > end_addr);
  assign addr1     = pc;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) state_nxt = FETCH;
      end
      FETCH: begin
        if (at_end)         state_nxt = DONE;
        else if (!op_known) state_nxt = FETCH;
        else if (truncated) state_nxt = DONE;
        else                state_nxt = CMD;
      end
      CMD: begin
        if (cmd_ready) state_nxt = (beats_left == 3'd0) ? FETCH : LOAD;
      end
      LOAD: begin
        state_nxt = DATA;
      end
      DATA: begin
        if (data_ready) state_nxt = (beats_left == 3'd1) ? FETCH : LOAD;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Status and valid outputs decode directly from state, so an async reset
  // drops them in the same instant the state returns to IDLE.
  always_comb begin
    busy       = 1'b0;
    done       = 1'b0;
    cmd_valid  = 1'b0;
    data_valid = 1'b0;
    case (state)
      FETCH, LOAD: busy = 1'b1;
      CMD:  begin busy = 1'b1; cmd_valid  = 1'b1; end
      DATA: begin busy = 1'b1; data_valid = 1'b1; end
      DONE: done = 1'b1;
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= 32'd0;
      addr2      <= 32'd0;
      beats_left <= 3'd0;
      err        <= 1'b0;
      cmd_op     <= 8'd0;
      cmd_mode   <= 4'd0;
      cmd_word   <= 32'd0;
      data       <= 128'd0;
      data_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            pc  <= base_addr & ~32'd3;
            err <= 1'b0;
          end
        end
        FETCH: begin
          if (!at_end) begin
            if (!op_known) begin
              // Skip the unknown word and keep walking.
              err <= 1'b1;
              pc  <= pc + 32'd4;
            end else if (truncated) begin
              err <= 1'b1;
            end else begin
              cmd_op     <= read0[7:0];
              cmd_mode   <= read0[11:8];
              cmd_word   <= read0;
              beats_left <= op_beats;
            end
          end
        end
        CMD: begin
          if (cmd_ready) begin
            if (beats_left == 3'd0) pc    <= pc + 32'd4;
            else                    addr2 <= pc + 32'd4;
          end
        end
        LOAD: begin
          data      <= {read4, read3, read2, read1};
          data_last <= (beats_left == 3'd1);
        end
        DATA: begin
          if (data_ready) begin
            beats_left <= beats_left - 3'd1;
            addr2      <= addr2 + 32'd16;
            // Last beat: next command follows directly after the operand block.
            if (beats_left == 3'd1) pc <= addr2 + 32'd16;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/cmd_fetch.md
Name: cmd_fetch

Overview:
- Initiator side of the command-memory read interface: walks a word-aligned command stream, decodes opcodes and streams operand words to the transform pipeline.
- Drives the instruction-address port (addr1 -> read0) and the 4-word operand-address port (addr2 -> read1..read4) of the command BRAM. Read data is combinational, valid in the same cycle as the address.
- Emits one decoded-command handshake per command, plus 128-bit operand beats for VERTEX and LOAD_MATRIX.

Parameters:
- OP_MATRIX_MODE, 8'h10, opcode for the matrix-mode select; mode is held in word bits [11:8]; no operands.
- OP_VERTEX, 8'h11, opcode for a vertex command; 4 operand words (1 beat).
- OP_LOAD_MATRIX, 8'h13, opcode for a matrix load; 16 operand words (4 beats).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  pulse: begin fetching at base_addr; ignored while busy=1.
- base_addr  in  32  byte address of the first command; bits [1:0] are ignored.
- end_addr  in  32  exclusive byte end of the stream.
- busy  out  1  high from the cycle after an accepted start until DONE.
- done  out  1  one-cycle pulse on stream completion.
- err  out  1  sticky error flag; cleared by an accepted start.
- addr1  out  32  instruction byte address (= pc).
- read0  in  32  command word at addr1.
- addr2  out  32  operand byte address.
- read1..read4  in  32 each  words at addr2, addr2+4, addr2+8, addr2+12.
- cmd_valid  out  1  decoded command available.
- cmd_ready  in  1  downstream accepts the command.
- cmd_op  out  8  opcode (read0[7:0]).
- cmd_mode  out  4  read0[11:8].
- cmd_word  out  32  raw command word.
- data_valid  out  1  operand beat available.
- data_ready  in  1  downstream accepts the beat.
- data  out  128  beat data: [31:0]=read1 ... [127:96]=read4 (lowest address in the low word).
- data_last  out  1  marks the final beat of the current command.

Behaviour:
- Reset values: state IDLE; pc, addr2, cmd_*, data, busy, done, err, cmd_valid, data_valid and data_last all 0.
- The FSM has six states: IDLE, FETCH, CMD, LOAD, DATA, DONE.
- IDLE:
  - On start, load pc <= {base_addr[31:2],2'b0}, clear err, go to FETCH. busy rises on the next edge.
- FETCH (addr1=pc):
  - If pc >= end_addr: go to DONE.
  - Otherwise decode read0[7:0]. n = 0 for MATRIX_MODE, 1 for VERTEX, 4 for LOAD_MATRIX.
  - Unknown opcode: set err, pc += 4, stay in FETCH. No cmd is emitted.
  - Known opcode with pc+4+16n > end_addr (truncated operands): set err, go to DONE. No cmd is emitted.
  - Otherwise register cmd_op, cmd_mode and cmd_word, assert cmd_valid, load beats_left=n, go to CMD.
  - Latency: start to cmd_valid is 2 cycles.
- CMD:
  - Hold cmd_* stable while cmd_valid=1 and cmd_ready=0.
  - On cmd_valid && cmd_ready: drop cmd_valid.
  - If n=0: pc += 4, go to FETCH.
  - Else: addr2 <= pc+4, go to LOAD.
- LOAD:
  - Capture {read4,read3,read2,read1} into data.
  - data_last <= (beats_left==1); assert data_valid; go to DATA.
- DATA:
  - Hold data while data_ready=0.
  - On handshake: drop data_valid, beats_left--, addr2 += 16.
  - If beats_left was 1: pc <= addr2+16, go to FETCH. Else go to LOAD.
  - Throughput is one beat per 2 cycles with ready held high.
- DONE:
  - Pulse done for one cycle, drop busy, go to IDLE.
- Handshake rules:
  - cmd_valid and data_valid are never high in the same cycle.
  - Once asserted, valid does not drop until its handshake.
- Address arithmetic is 32-bit unsigned and wraps modulo 2^32. An empty stream (base>=end) gives done 2 cycles after start with no cmd emitted.
- start while busy has no effect.
- Reset asserted mid-stream forces IDLE immediately, clears all valids, and emits no done.

Test Plan:
- Memory image: 0x00000010, 0x00000110, 0x80001013, 16 matrix words (first 0x42013333, last 0x41500000), 0x00000011, then 0x41800000, 0x41500000, 0x41400000, 0x41800000.
  - base=0, end=0x60, readies held high -> cmd sequence: op10/mode0; op10/mode1; op13, then 4 beats with beat0 data[31:0]=0x42013333 and beat3 data_last=1, data[127:96]=0x41500000; op11, then 1 beat data=0x41800000_41400000_41500000_41800000 with last=1; then done=1, err=0.
- Same image, cmd_ready and data_ready toggled pseudo-randomly -> identical transaction sequence; cmd_* and data stable while stalled.
- base=0, end=0x10 (LOAD_MATRIX truncated) -> two MATRIX_MODE cmds, then err=1 and done with no op13 cmd.
- Word 0x000000FF at addr 0, MATRIX_MODE at addr 4, end=8 -> err=1, single op10 cmd, done.
- base=end=0x20 -> done 2 cycles after start, no valids. A second start pulsed while busy in any run is ignored.
- rst_n dropped during DATA beat 2 of the LOAD_MATRIX -> all outputs 0 asynchronously. A restart then replays from base_addr.
